// File: rtl/intgen_pkg.sv
// intgen_pkg: shared constants for the multi-channel interrupt generator.
//   - Register offsets within one channel's 4-word window.
//   - Bit positions of the CTRL register fields.
package intgen_pkg;

    localparam logic [1:0] REG_LOAD   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;
    localparam int CTRL_IE  = 2;
    localparam int CTRL_W   = 3;

endpackage

// File: rtl/intgen_chan.sv
// intgen_chan: one timer channel (down-counter, reload, CTRL, pending flag).
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   i_load_we     : write LOAD this cycle (sets reload and counter)
//   i_ctrl_we     : write CTRL this cycle
//   i_clr_we      : W1C of pending this cycle (already qualified by data bit0)
//   i_wdata       : write data
//   o_count       : live counter value
//   o_reload      : reload register
//   o_ctrl        : {IE, PERIODIC, EN}
//   o_pending     : pending flag (unmasked)
module intgen_chan
    import intgen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_load_we,
    input  logic              i_ctrl_we,
    input  logic              i_clr_we,
    input  logic [CNT_W-1:0]  i_wdata,
    output logic [CNT_W-1:0]  o_count,
    output logic [CNT_W-1:0]  o_reload,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_pending
);

    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_reload;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_pending;
    logic              w_expire;

    // Expiry is judged on the pre-edge counter, so it still fires when a
    // LOAD write takes over the counter in the same cycle.
    assign w_expire = r_ctrl[CTRL_EN] && (r_count == CNT_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count   <= '0;
            r_reload  <= '0;
            r_ctrl    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (i_load_we) begin
                r_count  <= i_wdata;
                r_reload <= i_wdata;
            end else if (w_expire) begin
                // A zero reload in periodic mode parks the counter at 0.
                r_count <= (r_ctrl[CTRL_PER] && (r_reload != '0)) ? r_reload : '0;
            end else if (r_ctrl[CTRL_EN] && (r_count != '0)) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (i_ctrl_we) begin
                r_ctrl <= i_wdata[CTRL_W-1:0];
            end

            // Set beats clear when both land on the same edge.
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (i_clr_we) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_count   = r_count;
    assign o_reload  = r_reload;
    assign o_ctrl    = r_ctrl;
    assign o_pending = r_pending;

endmodule

// File: rtl/intgen_multi.sv
// intgen_multi: NCH independent interrupt timers behind one Wishbone slave.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   wb_adr_i            : word address {channel, reg[1:0]}
//   wb_dat_i / wb_dat_o : write / read data (CNT_W bits)
//   wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o : Wishbone handshake
//   irq_vec_o           : per-channel pending & IE
//   irq_o               : OR of irq_vec_o
//
// Handshake: a transfer is requested when wb_cyc_i & wb_stb_i is high and
// is accepted in that same cycle; wb_ack_o mirrors the request
// combinationally, there are no wait states. Writes commit on the clock
// edge that ends the acknowledged cycle; read data is valid while ack is high.
module intgen_multi
    import intgen_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int CH_AW = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CH_AW+1:0] wb_adr_i,
    input  logic [CNT_W-1:0] wb_dat_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [CNT_W-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic [NCH-1:0]   irq_vec_o,
    output logic             irq_o
);

    logic             w_acc;
    logic             w_wr;
    logic [CH_AW-1:0] w_ch;
    logic [1:0]       w_reg;
    logic [CNT_W-1:0] w_rdata;

    logic [CNT_W-1:0]  w_count   [NCH];
    logic [CNT_W-1:0]  w_reload  [NCH];
    logic [CTRL_W-1:0] w_ctrl    [NCH];
    logic [NCH-1:0]    w_pending;
    logic [NCH-1:0]    w_irq_vec;

    assign w_acc    = wb_cyc_i & wb_stb_i;
    assign w_wr     = w_acc & wb_we_i;
    assign w_ch     = wb_adr_i[CH_AW+1:2];
    assign w_reg    = wb_adr_i[1:0];
    assign wb_ack_o = w_acc;

    // Channels beyond NCH never match a generate index, so their writes
    // fall on the floor and their reads keep the default of 0.
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic w_hit;
        assign w_hit = w_wr && (w_ch == CH_AW'(g));

        intgen_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .i_load_we (w_hit && (w_reg == REG_LOAD)),
            .i_ctrl_we (w_hit && (w_reg == REG_CTRL)),
            .i_clr_we  (w_hit && (w_reg == REG_STATUS) && wb_dat_i[0]),
            .i_wdata   (wb_dat_i),
            .o_count   (w_count[g]),
            .o_reload  (w_reload[g]),
            .o_ctrl    (w_ctrl[g]),
            .o_pending (w_pending[g])
        );

        assign w_irq_vec[g] = w_pending[g] & w_ctrl[g][CTRL_IE];
    end

    always_comb begin
        w_rdata = '0;
        if (w_acc) begin
            for (int k = 0; k < NCH; k++) begin
                if (w_ch == CH_AW'(k)) begin
                    case (w_reg)
                        REG_LOAD:   w_rdata = w_reload[k];
                        REG_CTRL:   w_rdata = CNT_W'(w_ctrl[k]);
                        REG_COUNT:  w_rdata = w_count[k];
                        REG_STATUS: w_rdata = CNT_W'(w_pending[k]);
                        default:    w_rdata = '0;
                    endcase
                end
            end
        end
    end

    assign wb_dat_o  = w_rdata;
    assign irq_vec_o = w_irq_vec;
    assign irq_o     = |w_irq_vec;

endmodule

// File: tb/tb_intgen_multi.sv
// Directed bench for intgen_multi with NCH=4, CNT_W=8, CH_AW=3 so that
// channels 4..7 exist in the address map but not in hardware.
module tb_intgen_multi;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    localparam int CH_AW = 3;
    localparam int AW    = CH_AW + 2;

    localparam int R_LOAD   = 0;
    localparam int R_CTRL   = 1;
    localparam int R_COUNT  = 2;
    localparam int R_STATUS = 3;

    logic             clk_i;
    logic             rst_i;
    logic [AW-1:0]    wb_adr_i;
    logic [CNT_W-1:0] wb_dat_i;
    logic             wb_we_i;
    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic [CNT_W-1:0] wb_dat_o;
    logic             wb_ack_o;
    logic [NCH-1:0]   irq_vec_o;
    logic             irq_o;

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_q[$];

    intgen_multi #(
        .NCH   (NCH),
        .CNT_W (CNT_W),
        .CH_AW (CH_AW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .irq_vec_o (irq_vec_o),
        .irq_o     (irq_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] adr(input int ch, input int rg);
        return AW'((ch << 2) | rg);
    endfunction

    // ---------------- drivers ----------------
    // Every driver starts 1 time unit after a rising edge and returns 1 time
    // unit after the next one, so each call spans exactly one clock edge.
    task automatic idle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic op(input logic we, input logic [AW-1:0] a,
                      input logic [CNT_W-1:0] d, output logic [CNT_W-1:0] rdat);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = a;
        wb_dat_i = d;
        #2;
        rdat = wb_dat_o;
        chk("ack", 32'(wb_ack_o), 32'd1);
        @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input int ch, input int rg, input int d);
        logic [CNT_W-1:0] unused;
        op(1'b1, adr(ch, rg), CNT_W'(d), unused);
    endtask

    task automatic rd(input string tag, input int ch, input int rg, input int exp);
        logic [CNT_W-1:0] got;
        logic [CNT_W-1:0] e;
        exp_q.push_back(CNT_W'(exp));
        op(1'b0, adr(ch, rg), '0, got);
        e = exp_q.pop_front();
        chk(tag, 32'(got), 32'(e));
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic exp_irq [10];
        exp_irq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_i    = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle();

        // Reset state of every register.
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_irq_vec", 32'(irq_vec_o), 32'd0);
        chk("idle_ack", 32'(wb_ack_o), 32'd0);
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++)
                rd($sformatf("rst_ch%0d_reg%0d", c, r), c, r, 0);

        // Ch0 one-shot, LOAD=5.
        wr(0, R_LOAD, 5);
        wr(0, R_CTRL, 3'b101);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("os_irq_%0d", i), 32'(irq_o), (i >= 5) ? 32'd1 : 32'd0);
            rd($sformatf("os_count_%0d", i), 0, R_COUNT, (i < 5) ? 5 - i : 0);
        end
        chk("os_irq_vec", 32'(irq_vec_o), 32'b0001);
        rd("os_status", 0, R_STATUS, 1);
        rd("os_ctrl", 0, R_CTRL, 3'b101);
        rd("os_load", 0, R_LOAD, 5);
        wr(0, R_CTRL, 0);
        wr(0, R_STATUS, 1);
        chk("os_cleared_irq", 32'(irq_o), 32'd0);
        rd("os_cleared_status", 0, R_STATUS, 0);

        // Ch2 periodic, LOAD=3.
        wr(2, R_LOAD, 3);
        wr(2, R_CTRL, 3'b111);
        for (int i = 0; i < 6; i++)
            rd($sformatf("per_count_%0d", i), 2, R_COUNT, 3 - (i % 3));
        for (int i = 0; i < 10; i++) begin
            logic seen;
            seen = irq_vec_o[2];
            chk($sformatf("per_irq_%0d", i), 32'(seen), 32'(exp_irq[i]));
            chk($sformatf("per_irq_or_%0d", i), 32'(irq_o), 32'(exp_irq[i]));
            if (seen) wr(2, R_STATUS, 1);
            else      idle();
        end
        wr(2, R_CTRL, 0);
        wr(2, R_STATUS, 1);

        // Ch1: W1C in the same cycle as expiry, then LOAD on the expiry cycle.
        wr(1, R_LOAD, 2);
        wr(1, R_CTRL, 3'b101);
        idle();
        wr(1, R_STATUS, 1);
        rd("w1c_vs_expire", 1, R_STATUS, 1);
        wr(1, R_STATUS, 1);
        rd("w1c_clears", 1, R_STATUS, 0);
        wr(1, R_LOAD, 2);
        idle();
        wr(1, R_LOAD, 9);
        rd("load_vs_expire_count", 1, R_COUNT, 9);
        rd("load_vs_expire_status", 1, R_STATUS, 1);
        chk("load_vs_expire_irq_vec", 32'(irq_vec_o), 32'b0010);
        wr(1, R_CTRL, 0);
        wr(1, R_STATUS, 1);

        // Ch3: expiry with IE=0, then unmask.
        wr(3, R_LOAD, 2);
        wr(3, R_CTRL, 3'b001);
        idle();
        idle();
        chk("mask_irq_off", 32'(irq_o), 32'd0);
        rd("mask_status", 3, R_STATUS, 1);
        wr(3, R_CTRL, 3'b101);
        chk("unmask_irq", 32'(irq_o), 32'd1);
        chk("unmask_irq_vec", 32'(irq_vec_o), 32'b1000);
        wr(3, R_CTRL, 0);
        wr(3, R_STATUS, 1);
        chk("mask_cleared_irq", 32'(irq_o), 32'd0);

        // Ch0 freeze at 4, then resume.
        wr(0, R_LOAD, 6);
        wr(0, R_CTRL, 3'b001);
        rd("frz_count_6", 0, R_COUNT, 6);
        wr(0, R_CTRL, 0);
        for (int i = 0; i < 10; i++)
            rd($sformatf("frz_hold_%0d", i), 0, R_COUNT, 4);
        wr(0, R_CTRL, 3'b001);
        rd("frz_resume_4", 0, R_COUNT, 4);
        rd("frz_resume_3", 0, R_COUNT, 3);
        wr(0, R_CTRL, 0);

        // Channel isolation: ch1 periodic LOAD=4, ch3 periodic LOAD=7.
        wr(1, R_LOAD, 4);
        wr(1, R_CTRL, 3'b011);
        wr(3, R_LOAD, 7);
        wr(3, R_CTRL, 3'b011);
        rd("iso_ch3_count_7", 3, R_COUNT, 7);
        wr(1, R_LOAD, 4);
        wr(1, R_CTRL, 3'b011);
        rd("iso_ch3_count_4", 3, R_COUNT, 4);
        rd("iso_ch3_load", 3, R_LOAD, 7);
        rd("iso_ch3_ctrl", 3, R_CTRL, 3'b011);
        rd("iso_ch3_status", 3, R_STATUS, 0);

        // Unimplemented channels.
        wr(5, R_LOAD, 8'hAA);
        wr(5, R_CTRL, 3'b111);
        rd("bad_ch5_load", 5, R_LOAD, 0);
        rd("bad_ch5_ctrl", 5, R_CTRL, 0);
        rd("bad_ch5_count", 5, R_COUNT, 0);
        rd("bad_ch5_status", 5, R_STATUS, 0);
        rd("bad_ch4_load", 4, R_LOAD, 0);
        rd("bad_alias_ch1_load", 1, R_LOAD, 4);
        rd("bad_alias_ch1_ctrl", 1, R_CTRL, 3'b011);

        // Read data is 0 with no access in progress.
        wb_adr_i = adr(1, R_LOAD);
        #1;
        chk("idle_rdata", 32'(wb_dat_o), 32'd0);

        // Asynchronous reset mid-count; reads sampled before any clock edge.
        rst_i = 1'b1;
        #1;
        chk("arst_irq", 32'(irq_o), 32'd0);
        rd("arst_ch3_count", 3, R_COUNT, 0);
        rd("arst_ch1_count", 1, R_COUNT, 0);
        rd("arst_ch1_load", 1, R_LOAD, 0);
        rst_i = 1'b0;
        idle();

        // LOAD=0 never fires.
        wr(0, R_CTRL, 3'b111);
        repeat (3) idle();
        rd("zero_load_status", 0, R_STATUS, 0);
        rd("zero_load_count", 0, R_COUNT, 0);
        chk("zero_load_irq", 32'(irq_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
